// File: rtl/fifo_burst_drain.sv
// Read-side burst drain for an async FIFO, living in the rd_clk domain.
// Watches the FIFO flags, issues reads, captures the registered read data
// into a two-entry skid buffer and presents it as a valid/ready stream.
// Words are grouped into bursts of BURST_LEN, tagged with m_first/m_last.
// A partial burst is flushed after the FIFO sits short of a full burst
// for TIMEOUT cycles.
module fifo_burst_drain #(
  parameter int D_LENGTH  = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                rd_clk,
  input  logic                reset_n,
  input  logic                f_empty,
  input  logic                f_almost_empty,
  output logic                fifo_rd_en,
  input  logic [D_LENGTH-1:0] fifo_data,
  output logic [D_LENGTH-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_first,
  output logic                m_last,
  output logic                busy
);

  localparam logic [7:0] LP_BURST   = 8'(BURST_LEN);
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
  localparam logic [7:0] LP_TMAX    = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BURST = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0] r_rd_cnt;
  logic [7:0] w_rd_cnt_next;
  logic [7:0] r_tmr;
  logic [7:0] w_tmr_next;

  // One read may be in flight: its data shows up on fifo_data next cycle.
  // The tags decided at issue time travel alongside it.
  logic r_inflight;
  logic r_if_first;
  logic r_if_last;
  logic w_issue_first;
  logic w_issue_last;

  // Two-entry output buffer; data and tags are stored together so that
  // m_first/m_last always stay attached to their word.
  logic [D_LENGTH-1:0] r_buf_data  [2];
  logic                r_buf_first [2];
  logic                r_buf_last  [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_buf_cnt;

  logic       w_push;
  logic       w_pop;
  logic       w_cap_last;
  logic [1:0] w_occ;
  logic       w_credit;
  logic       w_rd_ok;

  assign w_push = r_inflight;
  assign w_pop  = m_valid && m_ready;

  // A flushed word is closed off either when the burst count is reached or
  // when the FIFO has run dry by the time the word lands.
  assign w_cap_last = r_if_last ||
                      ((r_state == S_FLUSH) && ((r_rd_cnt == LP_BURST) || f_empty));

  // Occupancy after this edge: a word leaving on this cycle frees its slot,
  // which is what lets a held-high m_ready sustain one word per cycle.
  assign w_occ    = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_credit = (w_occ < 2'd2);
  assign w_rd_ok  = !f_empty && w_credit;

  assign m_valid = (r_buf_cnt != 2'd0);
  assign m_data  = r_buf_data[r_rd_ptr];
  assign m_first = m_valid && r_buf_first[r_rd_ptr];
  assign m_last  = m_valid && r_buf_last[r_rd_ptr];
  assign busy    = (r_state != S_IDLE);

  // State, burst counter and wait timer registers.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_rd_cnt <= 8'd0;
      r_tmr    <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_rd_cnt <= w_rd_cnt_next;
      r_tmr    <= w_tmr_next;
    end
  end

  // Next-state, read issue and issue-time tagging.
  always_comb begin
    w_state_next  = r_state;
    w_rd_cnt_next = r_rd_cnt;
    w_tmr_next    = r_tmr;
    fifo_rd_en    = 1'b0;
    w_issue_first = 1'b0;
    w_issue_last  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!f_empty && !f_almost_empty) begin
          w_state_next = S_BURST;
        end else if (!f_empty) begin
          w_state_next = S_WAIT;
          w_tmr_next   = 8'd0;
        end
      end

      S_WAIT: begin
        if (r_tmr < LP_TIMEOUT) begin
          w_tmr_next = r_tmr + 8'd1;
        end
        // A FIFO that drains under us needs no flush, so empty wins over
        // the timeout.
        if (!f_almost_empty) begin
          w_state_next = S_BURST;
        end else if (f_empty) begin
          w_state_next = S_IDLE;
        end else if (r_tmr == LP_TMAX) begin
          w_state_next = S_FLUSH;
        end
      end

      S_BURST: begin
        // An empty FIFO simply stalls the burst; there is no timeout here.
        if (w_rd_ok && (r_rd_cnt < LP_BURST)) begin
          fifo_rd_en    = 1'b1;
          w_issue_first = (r_rd_cnt == 8'd0);
          w_issue_last  = (r_rd_cnt == LP_BURST - 8'd1);
          w_rd_cnt_next = r_rd_cnt + 8'd1;
          if (r_rd_cnt == LP_BURST - 8'd1) begin
            w_state_next = S_DRAIN;
          end
        end
      end

      S_FLUSH: begin
        // Single-issue: the last tag depends on f_empty at capture time, so
        // the next read waits until the previous word has landed.
        if (r_inflight) begin
          if (w_cap_last) begin
            w_state_next = S_DRAIN;
          end
        end else if (w_rd_ok && (r_rd_cnt < LP_BURST)) begin
          fifo_rd_en    = 1'b1;
          w_issue_first = (r_rd_cnt == 8'd0);
          w_rd_cnt_next = r_rd_cnt + 8'd1;
        end
      end

      S_DRAIN: begin
        if ((r_buf_cnt == 2'd0) && !r_inflight) begin
          w_state_next  = S_IDLE;
          w_rd_cnt_next = 8'd0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Track the read in flight together with its issue-time tags.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_if_first <= 1'b0;
      r_if_last  <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_if_first <= w_issue_first;
      r_if_last  <= w_issue_last;
    end
  end

  // Capture returning read data with its tags into the output buffer.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_data[0]  <= '0;
      r_buf_data[1]  <= '0;
      r_buf_first[0] <= 1'b0;
      r_buf_first[1] <= 1'b0;
      r_buf_last[0]  <= 1'b0;
      r_buf_last[1]  <= 1'b0;
    end else if (w_push) begin
      r_buf_data[r_wr_ptr]  <= fifo_data;
      r_buf_first[r_wr_ptr] <= r_if_first;
      r_buf_last[r_wr_ptr]  <= w_cap_last;
    end
  end

  // Buffer pointers and occupancy count.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a simple FIFO model feeds the DUT, and the
// expected stream (words plus first/last tags) is queued per scenario.
module tb_fifo_burst_drain;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          rd_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m_ready = 1'b0;
  logic          hold_empty = 1'b0;
  logic          fifo_clr = 1'b0;
  logic          f_empty;
  logic          f_almost_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_first;
  logic          m_last;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_burst_drain #(.D_LENGTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .rd_clk(rd_clk),
    .reset_n(reset_n),
    .f_empty(f_empty),
    .f_almost_empty(f_almost_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_first(m_first),
    .m_last(m_last),
    .busy(busy)
  );

  // FIFO model: registered read data, flags from the word count.
  logic [DW-1:0] mem [256];
  logic [7:0]    wptr = 8'd0;
  logic [7:0]    rptr = 8'd0;
  logic [7:0]    fcnt;
  assign fcnt           = wptr - rptr;
  assign f_empty        = (fcnt == 8'd0) || hold_empty;
  assign f_almost_empty = (fcnt < 8'(BL)) || hold_empty;

  always @(posedge rd_clk) begin
    if (fifo_clr) begin
      rptr <= wptr;
    end else if (fifo_rd_en) begin
      fifo_data <= mem[rptr];
      rptr      <= rptr + 8'd1;
    end
  end

  // Reference: each group of words placed in the FIFO leaves as one burst,
  // first tag on its first word and last tag on its final word.
  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } word_t;
  word_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] d;
    @(posedge rd_clk);
    #1;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      mem[wptr] = d;
      wptr = wptr + 8'd1;
      exp_q.push_back('{d: d, f: (i == 0), l: (i == n - 1)});
      $display("push word %0d data=%02h", i, d);
    end
  endtask

  // Run up to max_cyc cycles; report reads seen and whether all traffic ended.
  task automatic run(input int max_cyc, input bit rand_ready, output int nrd,
                     output int first_rd, output int last_rd, output bit done);
    nrd = 0;
    first_rd = -1;
    last_rd = -1;
    done = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge rd_clk);
      if (fifo_rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
      end
      if (exp_q.size() == 0 && !busy && !m_valid && (wptr == rptr)) begin
        done = 1'b1;
        break;
      end
      @(posedge rd_clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Stream monitor: ordering, tags, hold-under-backpressure, credit, read gating.
  int            cyc = 0;
  int            xfer_t[$];
  always @(posedge rd_clk) cyc <= cyc + 1;

  initial begin
    int            issued;
    int            xfered;
    bit            stall_prev;
    logic [DW-1:0] d_prev;
    logic          f_prev;
    logic          l_prev;
    word_t         w;
    issued = 0;
    xfered = 0;
    stall_prev = 1'b0;
    forever begin
      @(negedge rd_clk);
      if (!reset_n) begin
        issued = 0;
        xfered = 0;
        stall_prev = 1'b0;
      end else begin
        chk("rd_en_while_empty", 32'(fifo_rd_en && f_empty), 32'd0);
        chk("outstanding_le_2", 32'((issued - xfered) <= 2), 32'd1);
        if (stall_prev) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(d_prev));
          chk("hold_first", 32'(m_first), 32'(f_prev));
          chk("hold_last", 32'(m_last), 32'(l_prev));
        end
        if (m_valid && m_ready) begin
          chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            $display("xfer data=%02h first=%0d last=%0d (exp %02h %0d %0d)",
                     m_data, m_first, m_last, w.d, w.f, w.l);
            chk("xfer_data", 32'(m_data), 32'(w.d));
            chk("xfer_first", 32'(m_first), 32'(w.f));
            chk("xfer_last", 32'(m_last), 32'(w.l));
          end
          xfer_t.push_back(cyc);
        end
        stall_prev = m_valid && !m_ready;
        d_prev = m_data;
        f_prev = m_first;
        l_prev = m_last;
        issued += int'(fifo_rd_en);
        xfered += int'(m_valid && m_ready);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    int first_rd;
    int last_rd;
    bit done;
    int n;

    // Reset state.
    repeat (3) @(negedge rd_clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_first", 32'(m_first), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge rd_clk);
    #1;
    reset_n = 1'b1;
    run(20, 1'b0, nrd, first_rd, last_rd, done);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge rd_clk);
      n += int'(fifo_rd_en);
    end
    chk("idle_no_read", 32'(nrd + n), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Full burst at full throughput.
    m_ready = 1'b1;
    xfer_t.delete();
    push_words(BL);
    run(200, 1'b0, nrd, first_rd, last_rd, done);
    $display("full burst: reads=%0d first_rd=%0d last_rd=%0d done=%0d", nrd, first_rd, last_rd, done);
    chk("burst_done", 32'(done), 32'd1);
    chk("burst_reads", 32'(nrd), 32'(BL));
    chk("burst_rd_start", 32'(first_rd), 32'd2);
    chk("burst_rd_back2back", 32'(last_rd - first_rd), 32'(BL - 1));
    chk("burst_xfer_count", 32'(xfer_t.size()), 32'(BL));
    if (xfer_t.size() == BL)
      chk("burst_xfer_back2back", 32'(xfer_t[BL-1] - xfer_t[0]), 32'(BL - 1));
    chk("burst_busy_end", 32'(busy), 32'd0);

    // Backpressure: only two reads may be outstanding while stalled.
    m_ready = 1'b0;
    push_words(BL);
    run(10, 1'b0, nrd, first_rd, last_rd, done);
    $display("backpressure stall: reads=%0d valid=%0d", nrd, m_valid);
    chk("bp_reads_capped", 32'(nrd), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head_data", 32'(m_data), 32'(exp_q[0].d));
    run(400, 1'b1, n, first_rd, last_rd, done);
    $display("backpressure release: reads=%0d done=%0d", n, done);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_total_reads", 32'(nrd + n), 32'(BL));
    m_ready = 1'b1;

    // Partial flush after the wait timeout.
    push_words(2);
    run(200, 1'b0, nrd, first_rd, last_rd, done);
    $display("flush: reads=%0d first_rd=%0d last_rd=%0d done=%0d", nrd, first_rd, last_rd, done);
    chk("flush_done", 32'(done), 32'd1);
    chk("flush_reads", 32'(nrd), 32'd2);
    chk("flush_rd_start", 32'(first_rd), 32'(TO + 2));
    chk("flush_single_issue", 32'(last_rd - first_rd), 32'd2);

    // FIFO empties mid-burst, then refills.
    push_words(BL);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge rd_clk);
      n += int'(fifo_rd_en);
      if (n == 2) break;
    end
    chk("stall_pre_reads", 32'(n), 32'd2);
    @(posedge rd_clk);
    #1;
    hold_empty = 1'b1;
    run(10, 1'b0, nrd, first_rd, last_rd, done);
    $display("empty stall: reads=%0d busy=%0d", nrd, busy);
    chk("stall_no_read", 32'(nrd), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    hold_empty = 1'b0;
    run(200, 1'b0, nrd, first_rd, last_rd, done);
    $display("refill: reads=%0d done=%0d", nrd, done);
    chk("refill_reads", 32'(nrd), 32'd2);
    chk("refill_done", 32'(done), 32'd1);

    // Reset in the middle of a burst.
    push_words(BL);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge rd_clk);
      n += int'(m_valid && m_ready);
      if (n == 2) break;
    end
    chk("mid_rst_xfers", 32'(n), 32'd2);
    @(posedge rd_clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_first", 32'(m_first), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    fifo_clr = 1'b1;
    exp_q.delete();
    @(posedge rd_clk);
    #1;
    fifo_clr = 1'b0;
    reset_n = 1'b1;
    nrd = 0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge rd_clk);
      nrd += int'(fifo_rd_en);
      n += int'(m_valid);
    end
    $display("after mid-burst reset: reads=%0d valid_cycles=%0d", nrd, n);
    chk("post_rst_no_read", 32'(nrd), 32'd0);
    chk("post_rst_no_valid", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
